// File: rtl/linebuf_feed_pkg.sv
// Shared types and widths for the line-buffer feed path.
// The line buffer imports the same latency default.
package linebuf_feed_pkg;

    localparam int DWIDTH     = 16;
    localparam int LWIDTH     = 6;
    localparam int LB_LAT_DEF = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

endpackage

// File: rtl/linebuf_feed_if.sv
// Request, feature-memory and line-buffer signals of the feed block.
// slave is the streamer side, master the requester/memory side.
interface linebuf_feed_if
    import linebuf_feed_pkg::*;
#(
    parameter int MEMWIDTH = 12
) ();

    logic                     req;
    logic [LWIDTH-1:0]        img_size;
    logic [LWIDTH-1:0]        fil_size;
    logic [MEMWIDTH-1:0]      base_addr;
    logic [MEMWIDTH-1:0]      mem_addr;
    logic signed [DWIDTH-1:0] mem_rdata;
    logic                     buf_en;
    logic signed [DWIDTH-1:0] buf_input;
    logic                     win_valid;
    logic                     busy;
    logic                     ack;

    modport slave (
        input  req, img_size, fil_size, base_addr, mem_rdata,
        output mem_addr, buf_en, buf_input, win_valid, busy, ack
    );

    modport master (
        output req, img_size, fil_size, base_addr, mem_rdata,
        input  mem_addr, buf_en, buf_input, win_valid, busy, ack
    );

endinterface

// File: rtl/linebuf_feed_raster_count.sv
// Row/column position of a raster stream over an img_size square.
// last flags the final pixel (img_size-1, img_size-1).
module linebuf_feed_raster_count
    import linebuf_feed_pkg::*;
(
    input  logic              clk,
    input  logic              xrst,
    input  logic [LWIDTH-1:0] img_size,
    input  logic              clear,
    input  logic              step,
    output logic [LWIDTH-1:0] r,
    output logic [LWIDTH-1:0] c,
    output logic              last
);

    logic [LWIDTH-1:0] r_q, r_d;
    logic [LWIDTH-1:0] c_q, c_d;
    logic [LWIDTH-1:0] edge_m1;

    assign edge_m1 = img_size - LWIDTH'(1);
    assign r       = r_q;
    assign c       = c_q;
    assign last    = (r_q == edge_m1) && (c_q == edge_m1);

    // Advance column, wrapping into the next row at the image edge.
    always_comb begin
        r_d = r_q;
        c_d = c_q;
        if (clear) begin
            r_d = '0;
            c_d = '0;
        end else if (step) begin
            if (c_q == edge_m1) begin
                c_d = '0;
                r_d = r_q + LWIDTH'(1);
            end else begin
                c_d = c_q + LWIDTH'(1);
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk) begin
        if (xrst) begin
            r_q <= '0;
            c_q <= '0;
        end else begin
            r_q <= r_d;
            c_q <= c_d;
        end
    end

endmodule

// File: rtl/linebuf_feed.sv
// Streams one square feature map from memory into the line buffer,
// with start pulse, zero flush line and window-legality flags.
module linebuf_feed
    import linebuf_feed_pkg::*;
#(
    parameter int MAXSIZE  = 32,
    parameter int MAXLINE  = 5,
    parameter int MEMWIDTH = 12,
    parameter int LB_LAT   = LB_LAT_DEF
) (
    input logic           clk,
    input logic           xrst,
    linebuf_feed_if.slave bus
);

    localparam int                KW   = $clog2(MAXSIZE * MAXSIZE + 1);
    localparam logic [LWIDTH-1:0] FMAX = LWIDTH'(MAXLINE);

    state_t                   state_q, state_d;
    logic [LWIDTH-1:0]        img_q, img_d;
    logic [LWIDTH-1:0]        fil_q, fil_d;
    logic [KW-1:0]            n_q, n_d;
    logic [KW-1:0]            cnt_q, cnt_d;
    logic [MEMWIDTH-1:0]      mem_addr_q, mem_addr_d;
    logic                     rd_vld_q, rd_vld_d;
    logic                     buf_en_q, buf_en_d;
    logic signed [DWIDTH-1:0] buf_input_q, buf_input_d;
    logic                     pix_on_q, pix_on_d;
    logic [LB_LAT-1:0]        dly_q, dly_d;
    logic                     busy_q, busy_d;
    logic                     ack_q, ack_d;

    logic [LWIDTH-1:0] r;
    logic [LWIDTH-1:0] c;
    logic              last;
    logic              leg;
    logic              accept;

    linebuf_feed_raster_count u_cnt (
        .clk      (clk),
        .xrst     (xrst),
        .img_size (img_q),
        .clear    (buf_en_q),
        .step     (pix_on_q),
        .r        (r),
        .c        (c),
        .last     (last)
    );

    // busy_q still covers the ack cycle, so a req there is dropped.
    assign accept = (state_q == S_IDLE) && bus.req && !busy_q;

    assign leg = pix_on_q
              && (r >= fil_q - LWIDTH'(1))
              && (c >= fil_q - LWIDTH'(1))
              && (r < img_q);

    assign bus.mem_addr  = mem_addr_q;
    assign bus.buf_en    = buf_en_q;
    assign bus.buf_input = buf_input_q;
    assign bus.win_valid = dly_q[LB_LAT-1];
    assign bus.busy      = busy_q;
    assign bus.ack       = ack_q;

    // Sequencer: read N pixels, drain img+2 cycles, then acknowledge.
    always_comb begin
        state_d     = state_q;
        img_d       = img_q;
        fil_d       = fil_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        mem_addr_d  = '0;
        buf_en_d    = 1'b0;
        ack_d       = 1'b0;
        busy_d      = accept || (state_q != S_IDLE);
        rd_vld_d    = (state_q == S_READ);
        buf_input_d = rd_vld_q ? bus.mem_rdata : '0;
        pix_on_d    = buf_en_q || (pix_on_q && !last);
        dly_d[0]    = leg;
        for (int i = 1; i < LB_LAT; i++) begin
            dly_d[i] = dly_q[i-1];
        end
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    img_d = bus.img_size;
                    fil_d = (bus.fil_size > FMAX) ? FMAX : bus.fil_size;
                    n_d   = KW'(bus.img_size) * KW'(bus.img_size);
                    cnt_d = '0;
                    if (bus.img_size == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_READ;
                        mem_addr_d = bus.base_addr;
                    end
                end
            end
            S_READ: begin
                buf_en_d = (cnt_q == '0);
                if (cnt_q == n_q - KW'(1)) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d      = cnt_q + KW'(1);
                    mem_addr_d = mem_addr_q + MEMWIDTH'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == KW'(img_q) + KW'(1)) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + KW'(1);
                end
            end
            S_DONE: begin
                ack_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // All state and registered outputs; reset also empties the delay line.
    always_ff @(posedge clk) begin
        if (xrst) begin
            state_q     <= S_IDLE;
            img_q       <= '0;
            fil_q       <= '0;
            n_q         <= '0;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            rd_vld_q    <= 1'b0;
            buf_en_q    <= 1'b0;
            buf_input_q <= '0;
            pix_on_q    <= 1'b0;
            dly_q       <= '0;
            busy_q      <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            img_q       <= img_d;
            fil_q       <= fil_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            rd_vld_q    <= rd_vld_d;
            buf_en_q    <= buf_en_d;
            buf_input_q <= buf_input_d;
            pix_on_q    <= pix_on_d;
            dly_q       <= dly_d;
            busy_q      <= busy_d;
            ack_q       <= ack_d;
        end
    end

endmodule

// File: tb/tb_linebuf_feed.sv
// Directed and random jobs for linebuf_feed against a cycle-offset
// model of the stream, window flags and handshake.
module tb_linebuf_feed;
    import linebuf_feed_pkg::*;

    localparam int MW  = 12;
    localparam int LAT = LB_LAT_DEF;

    logic clk = 1'b0;
    logic xrst;
    always #5 clk = ~clk;

    linebuf_feed_if #(.MEMWIDTH(MW)) bus ();

    linebuf_feed #(
        .MAXSIZE  (32),
        .MAXLINE  (5),
        .MEMWIDTH (MW),
        .LB_LAT   (LAT)
    ) dut (
        .clk  (clk),
        .xrst (xrst),
        .bus  (bus.slave)
    );

    logic signed [DWIDTH-1:0] mem [4096];

    // Registered single-port feature memory.
    always @(posedge clk) bus.mem_rdata <= mem[bus.mem_addr];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample_zero(input string tag);
        chk({tag, ".mem_addr"}, bus.mem_addr, 0);
        chk({tag, ".buf_en"}, bus.buf_en, 0);
        chk({tag, ".buf_input"}, $unsigned(bus.buf_input), 0);
        chk({tag, ".win_valid"}, bus.win_valid, 0);
        chk({tag, ".busy"}, bus.busy, 0);
        chk({tag, ".ack"}, bus.ack, 0);
    endtask

    // Called at a negedge; req is presented for the cycle T that follows.
    // Sample at offset t is taken on the negedge inside cycle T+t.
    task automatic run_job(input int s, input int f, input int base,
                           input int glitch, input int rst_at,
                           output int wins);
        int n, ackt, k;
        logic [31:0] ep;
        logic ew;
        n    = s * s;
        ackt = (s == 0) ? 2 : n + s + 4;
        wins = 0;
        bus.req       = 1'b1;
        bus.img_size  = LWIDTH'(s);
        bus.fil_size  = LWIDTH'(f);
        bus.base_addr = MW'(base);
        for (int t = 1; t <= ackt + 1; t++) begin
            @(negedge clk);
            bus.req = (t == glitch);
            k  = t - 3;
            ep = 0;
            if (k >= 0 && k < n) ep = {16'b0, mem[(base + k) & 4095]};
            k  = t - 3 - LAT;
            ew = 1'b0;
            if (k >= 0 && k < n)
                ew = (k / s >= f - 1) && (k % s >= f - 1);
            chk("busy", bus.busy, t <= ackt);
            chk("ack", bus.ack, t == ackt);
            chk("buf_en", bus.buf_en, s > 0 && t == 2);
            chk("buf_input", $unsigned(bus.buf_input), ep);
            chk("win_valid", bus.win_valid, ew);
            if (t <= n) chk("mem_addr", bus.mem_addr, (base + t - 1) & 4095);
            if (bus.win_valid) wins++;
            if (t == rst_at) begin
                xrst = 1'b1;
                @(negedge clk);
                sample_zero("reset_mid");
                xrst = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        int w, s, f, b;
        for (int i = 0; i < 4096; i++) mem[i] = DWIDTH'($urandom);
        for (int i = 0; i < 16; i++) mem[16 + i] = DWIDTH'(i + 1);
        xrst          = 1'b1;
        bus.req       = 1'b0;
        bus.img_size  = '0;
        bus.fil_size  = '0;
        bus.base_addr = '0;
        repeat (3) @(negedge clk);
        sample_zero("reset");
        xrst = 1'b0;
        @(negedge clk);

        run_job(4, 3, 'h10, 0, 0, w);
        chk("win_count_4x3", w, 4);
        run_job(2, 1, 'hFFE, 0, 0, w);
        chk("win_count_wrap", w, 4);
        run_job(2, 3, 'h100, 0, 0, w);
        chk("win_count_small", w, 0);
        run_job(0, 2, 'h200, 0, 0, w);
        chk("win_count_empty", w, 0);
        run_job(4, 3, 'h10, 6, 0, w);
        chk("win_count_glitch", w, 4);
        run_job(4, 3, 'h10, 0, 8, w);
        @(negedge clk);
        sample_zero("post_reset");
        run_job(4, 3, 'h10, 0, 0, w);
        chk("win_count_rerun", w, 4);

        for (int j = 0; j < 6; j++) begin
            s = (j == 0) ? 32 : $urandom_range(0, 9);
            f = (j == 0) ? 5 : $urandom_range(1, 5);
            b = $urandom_range(0, 4095);
            run_job(s, f, b, (j == 1) ? 4 : 0, 0, w);
            chk("win_count_rand", w,
                (s >= f) ? (s - f + 1) * (s - f + 1) : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
